// File: rtl/residue_threshold_scheduler_if.sv
// Request/result bus between PE requesters, the residue threshold scheduler and the spike collector.
// Requester i owns slice i of req_valid/req_addr/req_psum and sees its own req_ready bit.
interface residue_threshold_scheduler_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_psum;
  logic                               spike_valid;
  logic                               spike_ready;
  logic [ADDR_WIDTH-1:0]              spike_addr;
  logic                               spike_bit;

  modport master (
    output req_valid, req_addr, req_psum, spike_ready,
    input  req_ready, spike_valid, spike_addr, spike_bit
  );

  modport slave (
    input  req_valid, req_addr, req_psum, spike_ready,
    output req_ready, spike_valid, spike_addr, spike_bit
  );
endinterface

// File: rtl/residue_threshold_scheduler.sv
// Shares one accumulate/threshold datapath among NUM_REQ requesters and owns the per-neuron residues.
// Round-robin grant, read-modify-write of the residue on the accept edge, one registered result per grant.
module residue_threshold_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_NEURON = 25,
  parameter int ADDR_WIDTH = 5,
  parameter int THRESHOLD  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  residue_threshold_scheduler_if.slave bus,
  input  logic                         clear,
  output logic                         busy,
  output logic                         addr_err
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NEURON - 1);
  localparam logic [DATA_WIDTH-1:0] THR       = DATA_WIDTH'(THRESHOLD);
  localparam logic [PTR_W-1:0]      LAST_REQ  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_EMIT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [PTR_W-1:0]      rr_ptr;
  logic                  clear_pend;
  logic [DATA_WIDTH-1:0] residue [NUM_NEURON];

  logic [PTR_W-1:0]      gnt;
  logic                  gnt_vld;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_psum;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] cur_res;
  logic [DATA_WIDTH:0]   sum_w;
  logic [DATA_WIDTH-1:0] sum_sat;
  logic                  fire;
  logic [DATA_WIDTH-1:0] new_res;

  // Scan downward so the last hit, i.e. the one closest to rr_ptr, wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[PTR_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt     = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    sel_addr = bus.req_addr[gnt];
    sel_psum = bus.req_psum[gnt];
    in_range = (sel_addr <= LAST_ADDR);
    cur_res  = in_range ? residue[sel_addr] : '0;
    sum_w    = {1'b0, cur_res} + {1'b0, sel_psum};
    sum_sat  = sum_w[DATA_WIDTH] ? '1 : sum_w[DATA_WIDTH-1:0];
    fire     = in_range && (sum_sat > THR);
    new_res  = fire ? (sum_sat - THR) : sum_sat;
  end

  // A same-cycle clear in IDLE pre-empts any grant.
  assign accept = (state == S_IDLE) && !clear && gnt_vld;
  assign busy   = (state == S_CLEAR);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign bus.req_ready[i] = accept && (gnt == PTR_W'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_CLEAR;
      clr_idx         <= '0;
      rr_ptr          <= '0;
      clear_pend      <= 1'b0;
      bus.spike_valid <= 1'b0;
      bus.spike_addr  <= '0;
      bus.spike_bit   <= 1'b0;
      addr_err        <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          residue[clr_idx] <= '0;
          clear_pend       <= 1'b0;
          if (clr_idx == LAST_ADDR) begin
            clr_idx <= '0;
            state   <= S_IDLE;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        S_IDLE: begin
          if (clear) begin
            state    <= S_CLEAR;
            clr_idx  <= '0;
            addr_err <= 1'b0;
          end else if (gnt_vld) begin
            rr_ptr          <= (gnt == LAST_REQ) ? '0 : gnt + 1'b1;
            bus.spike_valid <= 1'b1;
            bus.spike_addr  <= sel_addr;
            bus.spike_bit   <= fire;
            if (in_range) residue[sel_addr] <= new_res;
            else          addr_err          <= 1'b1;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.spike_ready) begin
            bus.spike_valid <= 1'b0;
            clear_pend      <= 1'b0;
            if (clear_pend || clear) begin
              state    <= S_CLEAR;
              clr_idx  <= '0;
              addr_err <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else if (clear) begin
            clear_pend <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_residue_threshold_scheduler.sv
// Randomized and directed bench for residue_threshold_scheduler against a queue/array reference model.
module tb_residue_threshold_scheduler;
  localparam int NR = 3, DW = 8, AW = 5, NN = 25, THR = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic busy, addr_err;

  always #5 clk = ~clk;

  residue_threshold_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

  residue_threshold_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_NEURON(NN), .ADDR_WIDTH(AW), .THRESHOLD(THR)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave), .clear(clear), .busy(busy), .addr_err(addr_err)
  );

  int checks = 0, errors = 0;
  int mres [32];
  int mrr;
  bit merr;
  int exp_g[$], act_g[$], exp_r[$], act_r[$];
  int onehot_bad;
  bit [NR-1:0] gflag;

  // Reference: results are encoded as addr*2 + spike.
  function automatic int model_apply(int a, int p);
    int s, b;
    b = 0;
    if (a >= NN) begin
      merr = 1'b1;
    end else begin
      s = mres[a] + p;
      if (s > 255) s = 255;
      if (s > THR) begin b = 1; s = s - THR; end
      mres[a] = s;
    end
    return a * 2 + b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mres[i] = 0;
    merr = 1'b0;
  endfunction

  task automatic clear_q();
    exp_g.delete(); act_g.delete(); exp_r.delete(); act_r.delete();
  endtask

  // One clock: observe at negedge, then drop valids of granted requesters just after the edge.
  task automatic tick();
    @(negedge clk);
    if ($countones(ifc.req_ready) > 1) onehot_bad++;
    for (int i = 0; i < NR; i++) begin
      if (ifc.req_ready[i]) begin
        int eg;
        eg = -1;
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (mrr + k) % NR;
          if (eg < 0 && ifc.req_valid[j]) eg = j;
        end
        exp_g.push_back(eg);
        act_g.push_back(i);
        if (eg >= 0) begin
          exp_r.push_back(model_apply(int'(ifc.req_addr[eg]), int'(ifc.req_psum[eg])));
          mrr = (eg + 1) % NR;
        end
        gflag[i] = 1'b1;
      end
    end
    if (ifc.spike_valid && ifc.spike_ready)
      act_r.push_back(int'(ifc.spike_addr) * 2 + int'(ifc.spike_bit));
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (gflag[i]) begin ifc.req_valid[i] = 1'b0; gflag[i] = 1'b0; end
  endtask

  task automatic send(input int i, input int a, input int p, output bit to);
    int n0, n;
    ifc.req_valid[i] = 1'b1;
    ifc.req_addr[i]  = AW'(a);
    ifc.req_psum[i]  = DW'(p);
    n0 = act_r.size();
    for (n = 0; n < 60; n++) begin
      tick();
      if (act_r.size() > n0 && !ifc.req_valid[i]) break;
    end
    to = (n == 60);
  endtask

  task automatic test_reset();
    int bc, rb;
    model_clear();
    mrr = 0;
    ifc.req_valid = '1;
    ifc.req_addr  = '0;
    ifc.req_psum  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ifc.spike_valid !== 1'b0) begin errors++; $display("FAIL reset_spike_valid: got %b expected 0", ifc.spike_valid); end
    checks++; if (ifc.spike_bit !== 1'b0) begin errors++; $display("FAIL reset_spike_bit: got %b expected 0", ifc.spike_bit); end
    checks++; if (ifc.spike_addr !== '0) begin errors++; $display("FAIL reset_spike_addr: got %0d expected 0", ifc.spike_addr); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    bc = 0; rb = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy !== 1'b1) break;
      bc++;
      if (ifc.req_ready !== '0) rb++;
      if (bc == NN) ifc.req_valid = '0;
      @(negedge clk);
    end
    checks++; if (bc != NN) begin errors++; $display("FAIL reset_busy_len: got %0d expected %0d", bc, NN); end
    checks++; if (rb != 0) begin errors++; $display("FAIL reset_ready_in_clear: got %0d cycles expected 0", rb); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_threshold();
    bit t0, t1, t2;
    int want [3];
    want = '{6, 7, 6};
    clear_q();
    send(0, 3, 40, t0);
    send(0, 3, 40, t1);
    send(0, 3, 48, t2);
    checks++; if (t0 | t1 | t2) begin errors++; $display("FAIL thr_timeout: got timeout expected results"); end
    checks++; if (act_r.size() != 3) begin errors++; $display("FAIL thr_count: got %0d expected 3", act_r.size()); end
    for (int k = 0; k < 3 && k < act_r.size(); k++) begin
      checks++; if (act_r[k] != want[k]) begin errors++; $display("FAIL thr_result%0d: got %0d expected %0d", k, act_r[k], want[k]); end
    end
    checks++; if (dut.residue[3] !== 8'd64) begin errors++; $display("FAIL thr_residue3: got %0d expected 64", dut.residue[3]); end
  endtask

  task automatic test_arbitration();
    bit t;
    int n;
    int want [3];
    send(2, 1, 0, t);
    clear_q();
    for (int i = 0; i < NR; i++) begin
      ifc.req_valid[i] = 1'b1; ifc.req_addr[i] = '0; ifc.req_psum[i] = 8'd10;
    end
    for (n = 0; n < 40; n++) begin
      if (act_r.size() == 3 && ifc.req_valid == '0) break;
      tick();
    end
    checks++; if (n == 40 || t) begin errors++; $display("FAIL arb_timeout: got %0d results expected 3", act_r.size()); end
    want = '{0, 1, 2};
    for (int k = 0; k < 3; k++) begin
      checks++; if (k >= act_g.size() || act_g[k] != want[k]) begin errors++; $display("FAIL arb_all_order%0d: got %0d expected %0d", k, (k < act_g.size()) ? act_g[k] : -1, want[k]); end
    end
    checks++; if (act_r != exp_r) begin errors++; $display("FAIL arb_all_results: got %0d entries expected %0d", act_r.size(), exp_r.size()); end
    clear_q();
    ifc.req_valid[1] = 1'b1;
    for (n = 0; n < 20 && act_g.size() < 1; n++) tick();
    ifc.req_valid[0] = 1'b1;
    ifc.req_valid[1] = 1'b1;
    for (n = 0; n < 40; n++) begin
      if (act_r.size() == 3 && ifc.req_valid == '0) break;
      tick();
    end
    want = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      checks++; if (k >= act_g.size() || act_g[k] != want[k]) begin errors++; $display("FAIL arb_pair_order%0d: got %0d expected %0d", k, (k < act_g.size()) ? act_g[k] : -1, want[k]); end
    end
    checks++; if (act_r != exp_r) begin errors++; $display("FAIL arb_pair_results: got %0d entries expected %0d", act_r.size(), exp_r.size()); end
  endtask

  task automatic test_backpressure();
    int n;
    clear_q();
    ifc.spike_ready = 1'b0;
    ifc.req_valid[0] = 1'b1; ifc.req_addr[0] = 5'd5; ifc.req_psum[0] = 8'd70;
    ifc.req_valid[1] = 1'b1; ifc.req_addr[1] = 5'd6; ifc.req_psum[1] = 8'd3;
    for (n = 0; n < 20 && act_g.size() < 1; n++) tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({ifc.spike_valid, ifc.spike_addr, ifc.spike_bit, ifc.req_ready} !== {1'b1, 5'd5, 1'b1, 3'b000}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b a=%0d s=%b rdy=%b expected v=1 a=5 s=1 rdy=000", k, ifc.spike_valid, ifc.spike_addr, ifc.spike_bit, ifc.req_ready);
      end
      tick();
    end
    ifc.spike_ready = 1'b1;
    for (n = 0; n < 20 && act_r.size() < 2; n++) tick();
    checks++; if (act_r.size() < 1 || act_r[0] != 11) begin errors++; $display("FAIL hold_result: got %0d expected 11", (act_r.size() > 0) ? act_r[0] : -1); end
    checks++; if (act_r != exp_r) begin errors++; $display("FAIL hold_results: got %0d entries expected %0d", act_r.size(), exp_r.size()); end
    checks++; if (act_g.size() != 2 || act_g[0] != 0 || act_g[1] != 1) begin errors++; $display("FAIL hold_grants: got %0d grants expected order 0,1", act_g.size()); end
  endtask

  task automatic test_saturation();
    bit t0, t1;
    clear_q();
    send(0, 7, 255, t0);
    send(1, 7, 100, t1);
    checks++; if (t0 | t1) begin errors++; $display("FAIL sat_timeout: got timeout expected results"); end
    checks++; if (act_r.size() != 2 || act_r[0] != 15 || act_r[1] != 15) begin errors++; $display("FAIL sat_spikes: got %0d results expected two fires at addr 7", act_r.size()); end
    checks++; if (dut.residue[7] !== 8'd191) begin errors++; $display("FAIL sat_residue7: got %0d expected 191", dut.residue[7]); end
  endtask

  task automatic test_clear();
    bit t;
    int bc, nz, n;
    clear_q();
    send(2, 30, 50, t);
    checks++; if (t || act_r.size() != 1 || act_r[0] != 60) begin errors++; $display("FAIL oor_result: got %0d expected 60", (act_r.size() > 0) ? act_r[0] : -1); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oor_addr_err: got %b expected 1", addr_err); end
    clear_q();
    ifc.req_valid[0] = 1'b1; ifc.req_addr[0] = 5'd4; ifc.req_psum[0] = 8'd9;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (act_g.size() != 0) begin errors++; $display("FAIL clear_wins: got %0d grants expected 0", act_g.size()); end
    model_clear();
    bc = 0;
    for (n = 0; n < 40 && busy === 1'b1; n++) begin
      bc++;
      if (addr_err !== 1'b0) begin errors++; checks++; $display("FAIL clear_addr_err: got %b expected 0", addr_err); end
      tick();
    end
    checks++; if (bc != NN) begin errors++; $display("FAIL clear_busy_len: got %0d expected %0d", bc, NN); end
    nz = 0;
    for (int a = 0; a < NN; a++) if (dut.residue[a] !== 8'd0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL clear_residues: got %0d nonzero expected 0", nz); end
    for (n = 0; n < 20 && act_r.size() < 1; n++) tick();
    checks++; if (act_r.size() != 1 || act_r[0] != 8) begin errors++; $display("FAIL post_clear_result: got %0d expected 8", (act_r.size() > 0) ? act_r[0] : -1); end

    clear_q();
    ifc.spike_ready = 1'b0;
    ifc.req_valid[0] = 1'b1; ifc.req_addr[0] = 5'd2; ifc.req_psum[0] = 8'd5;
    for (n = 0; n < 20 && act_g.size() < 1; n++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if ({busy, ifc.spike_valid} !== 2'b01) begin errors++; $display("FAIL emit_clear_pending: got busy=%b v=%b expected busy=0 v=1", busy, ifc.spike_valid); end
    tick(); tick();
    checks++; if ({busy, ifc.spike_valid} !== 2'b01) begin errors++; $display("FAIL emit_clear_hold: got busy=%b v=%b expected busy=0 v=1", busy, ifc.spike_valid); end
    ifc.spike_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL emit_clear_start: got busy=%b expected 1", busy); end
    model_clear();
    bc = 0;
    for (n = 0; n < 40 && busy === 1'b1; n++) begin bc++; tick(); end
    checks++; if (bc != NN) begin errors++; $display("FAIL emit_clear_len: got %0d expected %0d", bc, NN); end
    checks++; if (act_r.size() != 1 || act_r[0] != 4) begin errors++; $display("FAIL emit_clear_result: got %0d expected 4", (act_r.size() > 0) ? act_r[0] : -1); end
  endtask

  task automatic test_random();
    int n;
    clear_q();
    onehot_bad = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!ifc.req_valid[i] && $urandom_range(0, 2) == 0) begin
          ifc.req_valid[i] = 1'b1;
          ifc.req_addr[i]  = AW'($urandom_range(0, 27));
          ifc.req_psum[i]  = DW'($urandom_range(0, 255));
        end
      end
      ifc.spike_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ifc.spike_ready = 1'b1;
    for (n = 0; n < 100; n++) begin
      if (ifc.req_valid == '0 && !ifc.spike_valid) break;
      tick();
    end
    checks++; if (n == 100) begin errors++; $display("FAIL rand_drain: got pending traffic expected idle"); end
    checks++; if (act_g.size() != exp_g.size() || act_r.size() != exp_r.size()) begin errors++; $display("FAIL rand_counts: got %0d/%0d expected %0d/%0d", act_g.size(), act_r.size(), exp_g.size(), exp_r.size()); end
    for (int k = 0; k < act_g.size() && k < exp_g.size(); k++) begin
      checks++; if (act_g[k] != exp_g[k]) begin errors++; $display("FAIL rand_grant%0d: got %0d expected %0d", k, act_g[k], exp_g[k]); end
    end
    for (int k = 0; k < act_r.size() && k < exp_r.size(); k++) begin
      checks++; if (act_r[k] != exp_r[k]) begin errors++; $display("FAIL rand_result%0d: got %0d expected %0d", k, act_r[k], exp_r[k]); end
    end
    checks++; if (onehot_bad != 0) begin errors++; $display("FAIL rand_onehot: got %0d violations expected 0", onehot_bad); end
    checks++; if (addr_err !== merr) begin errors++; $display("FAIL rand_addr_err: got %b expected %b", addr_err, merr); end
  endtask

  initial begin
    ifc.req_valid   = '0;
    ifc.req_addr    = '0;
    ifc.req_psum    = '0;
    ifc.spike_ready = 1'b1;
    gflag           = '0;
    onehot_bad      = 0;
    test_reset();
    test_threshold();
    test_arbitration();
    test_backpressure();
    test_saturation();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
